// File: rtl/brr_pp_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : brr_pp_stream
// Brief    : Ping-pong bit-reversal reorder buffer with valid/ready streaming.
// Revision : 1.0 - initial release
// ============================================================================
module brr_pp_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int LOG_MIN    = 2,
    parameter int CFG_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CFG_W-1:0]      cfg_log2n,
    input  logic                  cfg_bypass,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  buffer_full,
    output logic                  buffer_empty,
    output logic [15:0]           frame_cnt
);

    localparam int                    c_depth   = 2 ** (ADDR_WIDTH + 1);
    localparam logic [CFG_W-1:0]      c_log_min = CFG_W'(LOG_MIN);
    localparam logic [CFG_W-1:0]      c_log_max = CFG_W'(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_ones    = '1;

    function automatic logic [CFG_W-1:0] clamp_log2n(input logic [CFG_W-1:0] v);
        if (v < c_log_min) return c_log_min;
        if (v > c_log_max) return c_log_max;
        return v;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    logic                   r_init;
    logic [1:0]             r_full;
    logic                   r_wr_bank;
    logic                   r_rd_bank;
    logic [ADDR_WIDTH-1:0]  r_wr_cnt;
    logic [ADDR_WIDTH-1:0]  r_rd_cnt;
    logic [1:0][CFG_W-1:0]  r_desc_log2n;
    logic [1:0]             r_desc_bypass;
    logic                   r_s1_valid;
    logic                   r_s1_last;
    logic [DATA_WIDTH-1:0]  r_s1_data;
    logic                   r_m_valid;
    logic                   r_m_last;
    logic [DATA_WIDTH-1:0]  r_m_data;
    logic [15:0]            r_frame_cnt;

    logic                   w_s_ready;
    logic                   w_s_fire;
    logic [CFG_W-1:0]       w_wr_log2n;
    logic [ADDR_WIDTH-1:0]  w_wr_last_idx;
    logic                   w_wr_done;
    logic [CFG_W-1:0]       w_rd_log2n;
    logic [ADDR_WIDTH-1:0]  w_rd_last_idx;
    logic                   w_adv;
    logic                   w_issue;
    logic                   w_rd_done;
    logic [ADDR_WIDTH-1:0]  w_rev_full;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic [1:0]             w_full_nxt;

    // Write side: word 0 takes the live config, later words use the latched descriptor
    assign w_s_ready     = r_init & ~r_full[r_wr_bank];
    assign w_s_fire      = s_valid & w_s_ready;
    assign w_wr_log2n    = (r_wr_cnt == '0) ? clamp_log2n(cfg_log2n) : r_desc_log2n[r_wr_bank];
    assign w_wr_last_idx = c_ones >> (c_log_max - w_wr_log2n);
    assign w_wr_done     = w_s_fire & (r_wr_cnt == w_wr_last_idx);

    generate
        for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
            assign w_rev_full[i] = r_rd_cnt[ADDR_WIDTH-1-i];
        end
    endgenerate

    // Full-width reversal shifted down leaves bitrev over the low L bits only
    assign w_rd_log2n    = r_desc_log2n[r_rd_bank];
    assign w_rd_last_idx = c_ones >> (c_log_max - w_rd_log2n);
    assign w_rd_addr     = r_desc_bypass[r_rd_bank] ? r_rd_cnt
                                                    : (w_rev_full >> (c_log_max - w_rd_log2n));
    assign w_adv         = ~r_m_valid | m_ready;
    assign w_issue       = r_full[r_rd_bank] & w_adv;
    assign w_rd_done     = w_issue & (r_rd_cnt == w_rd_last_idx);

    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
    end

    // RAM data is captured at issue so a refilling bank cannot clobber a stalled read
    always_ff @(posedge clk) begin
        if (w_s_fire) r_mem[{r_wr_bank, r_wr_cnt}] <= s_data;
        if (w_issue)  r_s1_data <= r_mem[{r_rd_bank, w_rd_addr}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init        <= 1'b0;
            r_full        <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_desc_log2n  <= {2{c_log_min}};
            r_desc_bypass <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_last     <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_m_data      <= '0;
            r_frame_cnt   <= '0;
        end else begin
            r_init <= 1'b1;
            r_full <= w_full_nxt;

            if (w_s_fire) begin
                if (r_wr_cnt == '0) begin
                    r_desc_log2n[r_wr_bank]  <= w_wr_log2n;
                    r_desc_bypass[r_wr_bank] <= cfg_bypass;
                end
                r_wr_cnt <= w_wr_done ? '0 : r_wr_cnt + ADDR_WIDTH'(1);
                if (w_wr_done) r_wr_bank <= ~r_wr_bank;
            end

            if (w_issue) begin
                r_rd_cnt <= w_rd_done ? '0 : r_rd_cnt + ADDR_WIDTH'(1);
                if (w_rd_done) r_rd_bank <= ~r_rd_bank;
            end

            // Both read stages move together whenever the output register frees up
            if (w_adv) begin
                r_s1_valid <= w_issue;
                r_s1_last  <= w_rd_done;
                r_m_valid  <= r_s1_valid;
                r_m_last   <= r_s1_valid & r_s1_last;
                if (r_s1_valid) r_m_data <= r_s1_data;
            end

            if (r_m_valid & m_ready & r_m_last) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign s_ready      = w_s_ready;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign m_last       = r_m_last;
    assign buffer_full  = &r_full;
    assign buffer_empty = ~|r_full & ~r_m_valid & (r_wr_cnt == '0);
    assign frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/brr_pp_stream.md
Name: brr_pp_stream

Overview:
- Parametrised bit-reversal reorder ping-pong buffer with valid/ready streaming on both sides.
- Sits between the FFT butterfly pipeline and downstream consumers; converts bit-reversed-order frames to natural order (or passes frames through unchanged in bypass).
- Frame length is selectable per frame at run time, up to 2^ADDR_WIDTH.
- Two banks let one frame be written while the previous one is read, sustaining 1 word/cycle.

Parameters:
DATA_WIDTH, 16, sample word width
ADDR_WIDTH, 7, log2 of max frame length; each bank is 2^ADDR_WIDTH words
LOG_MIN, 2, smallest legal cfg_log2n
CFG_W, 3, width of cfg_log2n; must hold ADDR_WIDTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_log2n  in  CFG_W  log2 frame length, sampled at frame start
cfg_bypass  in  1  1 = read in write order (no reversal), sampled at frame start
s_valid  in  1  input word valid
s_ready  out  1  input accepted when s_valid & s_ready
s_data  in  DATA_WIDTH  input word
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts when m_valid & m_ready
m_data  out  DATA_WIDTH  output word (registered)
m_last  out  1  marks final word of a frame
buffer_full  out  1  both banks hold unread frames
buffer_empty  out  1  both banks free and output register empty
frame_cnt  out  16  completed output frames, wraps at 2^16

Behaviour:
- Reset: s_ready=0 while rst_n low, 1 on first edge after release; m_valid=0, m_last=0, m_data=0, buffer_full=0, buffer_empty=1, frame_cnt=0. Bank flags, counters and bank pointers (both to bank 0) clear. RAM contents are not cleared. Reset mid-frame discards all partial and unread frames.
- Config: on acceptance of word 0 of a frame, cfg_log2n (clamped to [LOG_MIN, ADDR_WIDTH]) and cfg_bypass are latched into the write bank's descriptor. Mid-frame changes are ignored.
- Write side: s_ready = ~full[wr_bank]. Each accepted word goes to wr_bank at sequential address wr_cnt, then wr_cnt++. When word N-1 (N = 2^L) is accepted:
  - full[wr_bank] sets;
  - wr_bank toggles;
  - wr_cnt resets to 0.
- Read side has two stages.
  - Address stage: issues a RAM read when full[rd_bank] and (output register empty or being consumed this cycle).
  - Read address is bitrev_L(rd_cnt): reverse the low L bits, upper bits 0. In bypass the address is rd_cnt.
  - RAM read latency is 1 cycle into the m_data register; m_valid sets with the data.
  - On the address issue for rd_cnt = N-1: full[rd_bank] clears that cycle, rd_bank toggles, and m_last is flagged for that word.
- Latency: first m_valid is exactly 2 cycles after the edge accepting the last word of a frame, provided the output register is free.
- Throughput: with m_ready=1 and continuous s_valid, 1 word/cycle on both sides indefinitely. No bubbles between frames.
- Backpressure: m_valid & ~m_ready holds m_data/m_last stable and stalls address issue (no lost or duplicated words).
- Simultaneous events:
  - A bank may be freed by the read side and start filling on the same edge: the full flag clears, s_ready is 1 the next cycle.
  - Frames with different L may alternate banks; each bank reads with its own latched L and bypass.
- buffer_full = full[0] & full[1]. buffer_empty = ~full[0] & ~full[1] & ~m_valid & (wr_cnt==0).
- frame_cnt increments on the handshake of a word with m_last=1.

Test Plan:
- L=7, no bypass, s_data=i for i=0..127 → m_data sequence 0,64,32,96,16,…,127. m_last only on word 128 (value 127). frame_cnt=1.
- L=3, s_data=0..7 → 0,4,2,6,1,5,3,7 with m_last on 7. Then L=7 next frame → correct 128-word reversal (per-bank config).
- Continuous 4 frames L=7 with m_ready=1 → s_ready never drops after the first fill. m_valid is continuous from the first output to the end. Frame k outputs bitrev7(i)+128k.
- m_ready random 50%, s_valid random 70% → output equals the reference model word for word. buffer_full asserts and s_ready=0 when both banks are loaded.
- cfg_bypass=1, L=4, s_data=0..15 → m_data 0..15 in order. cfg_log2n=1 is clamped to L=2 → 4-word frame.
- rst_n pulsed low mid-write (word 50) and mid-read → outputs return to reset values asynchronously. The next frame 0..127 reorders correctly and frame_cnt restarts at 0.
